lis_stream_ctrl: RTL and testbench

Sequencer between the byte-wide GPIO streaming pins and the 32-bit linear insertion sorter (LIS) core. It packs input bytes into 32-bit elements and feeds one frame of up to LIS_SIZE elements to the sorter, marking the last element. It then drains the sorted elements and serialises them back to bytes, MSB first. It sits in the user project area, with the GPIO pins on one side and the sorter's word-stream ports on the other.

---
 rtl/lis_pkg.sv | 21 ++
 rtl/lis_byte_serializer.sv | 48 ++++
 rtl/lis_stream_ctrl.sv | 138 +++++++++++++
 tb/tb_lis_stream_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lis_pkg.sv
// Shared types and constants for the LIS byte-stream controller and its serializer.
package lis_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int ELEM_W         = 32;
  localparam int BYTES_PER_ELEM = 4;
  localparam bit MSB_FIRST      = 1'b1;

  // Byte number idx of an element in wire order.
  function automatic logic [7:0] byte_sel(input logic [ELEM_W-1:0] word, input logic [1:0] idx);
    logic [ELEM_W-1:0] sh;
    sh = MSB_FIRST ? (word << {idx, 3'b000}) : (word >> {idx, 3'b000});
    return MSB_FIRST ? sh[ELEM_W-1 -: 8] : sh[7:0];
  endfunction

endpackage

// File: rtl/lis_byte_serializer.sv
// Holds one sorted 32-bit element and hands it out a byte at a time on a
// valid/ready byte stream.
module lis_byte_serializer
  import lis_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  input  logic [ELEM_W-1:0] i_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_word_done
);

  logic [ELEM_W-1:0] r_obuf;
  logic [1:0]        r_bidx;
  logic              r_ofull;
  logic              w_load;
  logic              w_xfer;

  assign o_word_ready = i_en && !r_ofull;
  assign w_load       = i_word_valid && o_word_ready;
  assign w_xfer       = r_ofull && i_ready;
  assign o_word_done  = w_xfer && (r_bidx == 2'(BYTES_PER_ELEM - 1));
  assign o_valid      = r_ofull;
  assign o_data       = byte_sel(r_obuf, r_bidx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_obuf  <= '0;
      r_bidx  <= '0;
      r_ofull <= 1'b0;
    end else if (w_load) begin
      r_obuf  <= i_word;
      r_bidx  <= '0;
      r_ofull <= 1'b1;
    end else if (w_xfer) begin
      r_bidx <= r_bidx + 2'd1;
      if (o_word_done) begin
        r_ofull <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lis_stream_ctrl.sv
// Sequencer between the GPIO byte streams and the linear insertion sorter:
// packs bytes into elements, feeds one frame, then drains it back as bytes.
module lis_stream_ctrl
  import lis_pkg::*;
#(
  parameter int LIS_SIZE = 8,
  parameter int CNT_W    = $clog2(LIS_SIZE + 1)
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              enable,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              s_in_valid,
  input  logic              s_in_ready,
  output logic [ELEM_W-1:0] s_in_data,
  output logic              s_in_last,
  input  logic              s_out_valid,
  output logic              s_out_ready,
  input  logic [ELEM_W-1:0] s_out_data,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       frames_done
);

  state_e            r_state;
  logic [ELEM_W-1:0] r_word;
  logic [1:0]        r_bidx;
  logic              r_wfull;
  logic              r_s_in_last;
  logic              r_frame_err;
  logic [CNT_W-1:0]  r_ecount;
  logic [CNT_W-1:0]  r_ocount;
  logic [CNT_W-1:0]  r_nelem;
  logic [15:0]       r_frames_done;

  logic              w_in_xfer;
  logic              w_sin_xfer;
  logic              w_word_end;
  logic              w_at_cap;
  logic              w_drain;
  logic              w_word_done;
  logic              w_frame_out;
  logic [ELEM_W-1:0] w_shifted;
  logic [ELEM_W-1:0] w_justified;

  assign in_ready    = (r_state == LOAD) && !r_wfull;
  assign w_in_xfer   = in_valid && in_ready;
  assign w_sin_xfer  = r_wfull && s_in_ready;
  assign w_shifted   = {r_word[ELEM_W-9:0], in_data};
  // A short final word is shifted up so its bytes stay MSB-aligned with 00 below.
  assign w_justified = w_shifted << {~r_bidx, 3'b000};
  assign w_word_end  = (r_bidx == 2'(BYTES_PER_ELEM - 1)) || in_last;
  assign w_at_cap    = (r_ecount == CNT_W'(LIS_SIZE - 1));
  assign w_drain     = (r_state == DRAIN);
  assign w_frame_out = w_word_done && ((r_ocount + CNT_W'(1)) == r_nelem);

  assign s_in_valid  = r_wfull;
  assign s_in_data   = r_word;
  assign s_in_last   = r_s_in_last;
  assign busy        = (r_state != IDLE);
  assign frame_err   = r_frame_err;
  assign frames_done = r_frames_done;

  lis_byte_serializer u_ser (
    .clk          (clock),
    .rst_n        (resetb),
    .i_en         (w_drain),
    .i_word_valid (s_out_valid),
    .o_word_ready (s_out_ready),
    .i_word       (s_out_data),
    .o_valid      (out_valid),
    .i_ready      (out_ready),
    .o_data       (out_data),
    .o_word_done  (w_word_done)
  );

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state       <= IDLE;
      r_word        <= '0;
      r_bidx        <= '0;
      r_wfull       <= 1'b0;
      r_s_in_last   <= 1'b0;
      r_frame_err   <= 1'b0;
      r_ecount      <= '0;
      r_ocount      <= '0;
      r_nelem       <= '0;
      r_frames_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) r_state <= LOAD;
        end
        LOAD: begin
          if (w_in_xfer) begin
            if (w_word_end) begin
              r_word      <= w_justified;
              r_bidx      <= '0;
              r_wfull     <= 1'b1;
              r_s_in_last <= in_last || w_at_cap;
              if (in_last && (r_bidx != 2'(BYTES_PER_ELEM - 1))) r_frame_err <= 1'b1;
            end else begin
              r_word <= w_shifted;
              r_bidx <= r_bidx + 2'd1;
            end
          end
          if (w_sin_xfer) begin
            r_wfull     <= 1'b0;
            r_s_in_last <= 1'b0;
            r_ecount    <= r_ecount + CNT_W'(1);
            if (r_s_in_last) begin
              r_nelem <= r_ecount + CNT_W'(1);
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_word_done) r_ocount <= r_ocount + CNT_W'(1);
          if (w_frame_out) begin
            r_frames_done <= r_frames_done + 16'd1;
            r_ecount      <= '0;
            r_ocount      <= '0;
            r_nelem       <= '0;
            r_state       <= enable ? LOAD : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lis_stream_ctrl.sv
// Randomised bench for lis_stream_ctrl: byte-level frame model plus a simple
// sorter model on the word-stream side.
module tb_lis_stream_ctrl;

  localparam int LIS_SIZE = 4;

  logic        clock = 1'b0;
  logic        resetb, enable;
  logic        in_valid, in_ready, in_last;
  logic [7:0]  in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        s_in_valid, s_in_ready, s_in_last;
  logic [31:0] s_in_data;
  logic        s_out_valid, s_out_ready;
  logic [31:0] s_out_data;
  logic        busy, frame_err;
  logic [15:0] frames_done;

  always #5 clock = ~clock;

  lis_stream_ctrl #(.LIS_SIZE(LIS_SIZE)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .s_in_valid  (s_in_valid),
    .s_in_ready  (s_in_ready),
    .s_in_data   (s_in_data),
    .s_in_last   (s_in_last),
    .s_out_valid (s_out_valid),
    .s_out_ready (s_out_ready),
    .s_out_data  (s_out_data),
    .busy        (busy),
    .frame_err   (frame_err),
    .frames_done (frames_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: byte source, expected elements and expected output bytes.
  logic [8:0]  src_q[$];
  logic [7:0]  m_bytes[$];
  logic [31:0] m_frame[$];
  logic [32:0] exp_elem_q[$];
  logic [7:0]  exp_out_q[$];
  int          exp_len_q[$];
  logic [31:0] sort_in_q[$];
  logic [31:0] sort_out_q[$];
  int          exp_frames = 0;
  bit          exp_err = 0;

  bit x_in = 0, x_sov = 0, chk_sin_lat = 0, chk_oval_lat = 0, draining = 0;
  int bytes_in_word = 0, frame_bytes = 0, out_cnt = 0, cyc = 0, sir_hold = 0;
  int p_in = 100, p_sov = 100, or_mode = 0, sir_mode = 0;

  task automatic push_byte(input logic [7:0] b, input bit last);
    logic [31:0] v;
    bit          el;
    src_q.push_back({last, b});
    m_bytes.push_back(b);
    if (m_bytes.size() == 4 || last) begin
      v = 32'h0;
      for (int k = 0; k < 4; k++) v = (v << 8) | ((k < m_bytes.size()) ? 32'(m_bytes[k]) : 32'h0);
      if (last && m_bytes.size() != 4) exp_err = 1;
      el = last || (m_frame.size() == LIS_SIZE - 1);
      m_frame.push_back(v);
      exp_elem_q.push_back({el, v});
      m_bytes.delete();
      if (el) begin
        m_frame.sort();
        for (int i = 0; i < m_frame.size(); i++)
          for (int k = 0; k < 4; k++) exp_out_q.push_back(8'(m_frame[i] >> (24 - 8 * k)));
        exp_len_q.push_back(4 * m_frame.size());
        exp_frames++;
        m_frame.delete();
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit last);
    for (int k = 0; k < 4; k++) push_byte(8'(w >> (24 - 8 * k)), last && (k == 3));
  endtask

  task automatic step();
    logic [8:0]  t;
    logic [32:0] e;
    logic [7:0]  b;
    @(negedge clock);
    cyc++;
    if (chk_sin_lat)  check("sin_latency", 32'(s_in_valid), 32'd1);
    if (chk_oval_lat) check("out_valid_latency", 32'(out_valid), 32'd1);
    chk_sin_lat = 0; chk_oval_lat = 0;
    if (x_in) in_valid = 1'b0;
    if (x_sov) s_out_valid = 1'b0;
    x_in = 0; x_sov = 0;

    if (!in_valid && src_q.size() > 0 && $urandom_range(99) < p_in) in_valid = 1'b1;
    if (in_valid) begin
      in_data = src_q[0][7:0];
      in_last = src_q[0][8];
    end else begin
      in_data = 8'h00;
      in_last = 1'b0;
    end
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = cyc[0];
      default: out_ready = ($urandom_range(1) == 1);
    endcase
    case (sir_mode)
      0: s_in_ready = 1'b1;
      1: begin
        if (s_in_valid && sir_hold < 5) begin
          s_in_ready = 1'b0;
          sir_hold++;
        end else begin
          s_in_ready = 1'b1;
        end
      end
      default: s_in_ready = ($urandom_range(1) == 1);
    endcase
    if (!s_out_valid && sort_out_q.size() > 0 && $urandom_range(99) < p_sov) s_out_valid = 1'b1;
    s_out_data = s_out_valid ? sort_out_q[0] : 32'h0;

    if (s_in_valid) check("in_ready_while_wfull", 32'(in_ready), 32'd0);
    if (draining)   check("in_ready_in_drain", 32'(in_ready), 32'd0);

    if (in_valid && in_ready) begin
      x_in = 1;
      t = src_q.pop_front();
      bytes_in_word++;
      if (t[8] || bytes_in_word == 4) begin
        bytes_in_word = 0;
        chk_sin_lat = 1;
      end
    end
    if (s_in_valid && s_in_ready) begin
      sir_hold = 0;
      if (exp_elem_q.size() == 0) begin
        check("sin_valid_unexpected", 32'(s_in_valid), 32'd0);
      end else begin
        e = exp_elem_q.pop_front();
        check("sin_data", s_in_data, e[31:0]);
        check("sin_last", 32'(s_in_last), 32'(e[32]));
        if (e[32]) draining = 1;
      end
      sort_in_q.push_back(s_in_data);
      if (s_in_last) begin
        sort_in_q.sort();
        for (int i = 0; i < sort_in_q.size(); i++) sort_out_q.push_back(sort_in_q[i]);
        sort_in_q.delete();
      end
    end
    if (s_out_valid && s_out_ready) begin
      x_sov = 1;
      chk_oval_lat = 1;
      void'(sort_out_q.pop_front());
    end
    if (out_valid && out_ready) begin
      out_cnt++;
      if (exp_out_q.size() == 0) begin
        check("out_valid_unexpected", 32'(out_valid), 32'd0);
      end else begin
        b = exp_out_q.pop_front();
        check("out_byte", 32'(out_data), 32'(b));
        frame_bytes++;
        if (exp_len_q.size() > 0 && frame_bytes == exp_len_q[0]) begin
          void'(exp_len_q.pop_front());
          frame_bytes = 0;
          draining = 0;
        end
      end
    end
  endtask

  task automatic run(input int budget);
    int c = 0;
    while ((src_q.size() > 0 || exp_out_q.size() > 0 || exp_elem_q.size() > 0) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) check("run_timeout", 32'(exp_out_q.size() + src_q.size()), 32'd0);
    repeat (4) step();
    check("frames_done", 32'(frames_done), 32'(exp_frames));
    check("frame_err", 32'(frame_err), 32'(exp_err));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;
    int c;
    resetb = 1'b1; enable = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    s_in_ready = 1'b0; s_out_valid = 1'b0; s_out_data = 32'h0;
    #2 resetb = 1'b0;
    #1;
    check("reset_flags", 32'({in_ready, out_valid, s_in_valid, s_in_last, s_out_ready, busy, frame_err}), 32'd0);
    check("reset_data", 32'({out_data, s_in_data[23:0]}) | s_in_data, 32'd0);
    check("reset_frames_done", 32'(frames_done), 32'd0);
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    step();
    check("load_busy", 32'(busy), 32'd1);

    // Full frame
    push_word(32'h5, 0); push_word(32'h2, 0); push_word(32'h9, 0); push_word(32'h1, 1);
    run(500);

    // Short frame, then controller must be back in LOAD
    start = out_cnt;
    push_word(32'hA, 0); push_word(32'h3, 1);
    run(500);
    check("short_out_count", 32'(out_cnt - start), 32'd8);
    check("short_back_in_load", 32'(busy), 32'd1);

    // Partial final word
    push_word(32'h11223344, 0); push_byte(8'h55, 0); push_byte(8'h66, 1);
    run(500);

    // Back-pressure on both sides
    or_mode = 1; sir_mode = 1;
    push_word(32'h5, 0); push_word(32'h2, 0); push_word(32'h9, 0); push_word(32'h1, 1);
    run(800);
    or_mode = 0; sir_mode = 0;

    // Overlength: 20 bytes without in_last, then close the second frame
    for (int i = 0; i < 20; i++) push_byte(8'($urandom), 0);
    push_word($urandom, 1);
    run(1000);

    // Random frames with random handshakes
    or_mode = 2; sir_mode = 2; p_in = 60; p_sov = 60;
    for (int f = 0; f < 20; f++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) push_byte(8'($urandom), (i == n - 1) && ($urandom_range(3) != 0));
    end
    push_word($urandom, 1);
    run(20000);
    or_mode = 0; sir_mode = 0; p_in = 100; p_sov = 100;

    // Asynchronous reset in the middle of a drain
    push_word(32'h77, 0); push_word(32'h44, 0); push_word(32'h66, 0); push_word(32'h55, 1);
    start = out_cnt;
    c = 0;
    while (out_cnt - start < 3 && c < 500) begin
      step();
      c++;
    end
    if (c >= 500) check("pre_reset_timeout", 32'(out_cnt - start), 32'd3);
    @(posedge clock);
    #2 resetb = 1'b0;
    #1;
    check("async_rst_flags", 32'({in_ready, out_valid, s_in_valid, s_in_last, s_out_ready, busy, frame_err}), 32'd0);
    check("async_rst_out_data", 32'(out_data), 32'd0);
    check("async_rst_s_in_data", s_in_data, 32'd0);
    check("async_rst_frames_done", 32'(frames_done), 32'd0);
    src_q.delete(); m_bytes.delete(); m_frame.delete(); exp_elem_q.delete();
    exp_out_q.delete(); exp_len_q.delete(); sort_in_q.delete(); sort_out_q.delete();
    exp_frames = 0; exp_err = 0;
    x_in = 0; x_sov = 0; chk_sin_lat = 0; chk_oval_lat = 0; draining = 0;
    bytes_in_word = 0; frame_bytes = 0; sir_hold = 0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; s_out_valid = 1'b0; s_out_data = 32'h0;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    step(); step();
    check("post_reset_idle", 32'(busy), 32'd0);
    check("post_reset_frames_done", 32'(frames_done), 32'd0);
    enable = 1'b1;
    push_word(32'hC0DE, 0); push_word(32'h0042, 0); push_word(32'hBEEF, 0); push_word(32'h0007, 1);
    run(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
